// File: rtl/gate2_truth_checker_if.sv
// gate2_truth_checker_if: bundles the run handshake, the gate-under-test drive/sense
// wires and the result outputs of gate2_truth_checker.
//   master : the checker itself (drives drv_a/drv_b and results, senses start/dut_f)
//   slave  : the environment (issues start, supplies dut_f, consumes results)
interface gate2_truth_checker_if;
  logic       start;      // run request
  logic       dut_f;      // F output of the gate under test
  logic       drv_a;      // gate input A
  logic       drv_b;      // gate input B
  logic       busy;       // run in progress
  logic       done;       // one-cycle end-of-run pulse
  logic       pass;       // last run had no mismatches
  logic [2:0] err_count;  // mismatches in last run
  logic [3:0] fail_mask;  // per-vector mismatch flags, bit idx = {A,B}

  modport master (
    input  start,
    input  dut_f,
    output drv_a,
    output drv_b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_mask
  );

  modport slave (
    output start,
    output dut_f,
    input  drv_a,
    input  drv_b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_mask
  );
endinterface

// File: rtl/gate2_truth_checker.sv
// gate2_truth_checker: exhaustive two-input gate checker. On start it walks the four
// input vectors {A,B} = 00,01,10,11, holds each for SETTLE cycles, samples the gate
// output and compares it with EXPECTED[{A,B}]. Results (fail mask, error count, pass)
// are held until the next accepted start; done pulses for one cycle at the end.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every output
//   bus_io : gate2_truth_checker_if master modport (start, dut_f in; drive/results out)
// Parameters:
//   EXPECTED : expected F per vector, bit index {A,B}; default is the AND truth table
//   SETTLE   : cycles each vector is held before sampling, legal range 1..15
module gate2_truth_checker #(
  parameter logic [3:0]  EXPECTED = 4'b1000,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  gate2_truth_checker_if.master        bus_io
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic       drv_a_q;
  logic       drv_b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_count_q;
  logic [3:0] fail_mask_q;

  // Result state as it will be after the current sample is folded in; only
  // committed in StSample. Lets pass include the last vector's outcome.
  logic       mismatch;
  logic [2:0] err_count_d;
  logic [3:0] fail_mask_d;

  always_comb begin
    mismatch    = bus_io.dut_f != EXPECTED[idx_q];
    err_count_d = err_count_q + {2'b00, mismatch};
    fail_mask_d = fail_mask_q;
    if (mismatch) begin
      fail_mask_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      drv_a_q     <= 1'b0;
      drv_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_mask_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            drv_a_q     <= 1'b0;
            drv_b_q     <= 1'b0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            fail_mask_q <= 4'd0;
            state_q     <= StDrive;
          end
        end
        StDrive: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SettleLast) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          err_count_q <= err_count_d;
          fail_mask_q <= fail_mask_d;
          if (idx_q != 2'd3) begin
            idx_q              <= idx_q + 2'd1;
            {drv_a_q, drv_b_q} <= idx_q + 2'd1;
            cnt_q              <= 4'd0;
            state_q            <= StDrive;
          end else begin
            // Drive pins stay at 11 until the next accepted start.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == 3'd0);
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.drv_a     = drv_a_q;
  assign bus_io.drv_b     = drv_b_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.pass      = pass_q;
  assign bus_io.err_count = err_count_q;
  assign bus_io.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate2_truth_checker.sv
// Bench for gate2_truth_checker: two instances (AND table / SETTLE=1 and XOR table /
// SETTLE=3) each wrapped around a truth-table gate model. Expected results come from
// comparing the modelled gate table with the expected table vector by vector; expected
// timing comes from the per-vector period SETTLE+1.
module tb_gate2_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  gate2_truth_checker_if if0 ();
  gate2_truth_checker_if if1 ();

  // Gate-under-test models: arbitrary two-input functions given as truth tables.
  logic [3:0] tt0;
  logic [3:0] tt1;
  assign if0.dut_f = tt0[{if0.drv_a, if0.drv_b}];
  assign if1.dut_f = tt1[{if1.drv_a, if1.drv_b}];

  gate2_truth_checker #(
    .EXPECTED (4'b1000),
    .SETTLE   (1)
  ) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if0.master)
  );

  gate2_truth_checker #(
    .EXPECTED (4'b0110),
    .SETTLE   (3)
  ) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if1.master)
  );

  // Packed view: [11] busy [10] done [9] pass [8:6] err_count [5:2] fail_mask [1:0] {a,b}
  logic [11:0] pack0;
  logic [11:0] pack1;
  logic [11:0] obs;
  int          sel;
  assign pack0 = {if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask,
                  if0.drv_a, if0.drv_b};
  assign pack1 = {if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_mask,
                  if1.drv_a, if1.drv_b};
  assign obs   = (sel == 0) ? pack0 : pack1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) if0.start = v;
    else        if1.start = v;
  endtask

  // One complete run; called at #1 after a rising edge with the instance idle.
  task automatic run(input int s, input logic [3:0] tt, input logic [3:0] exp_tt,
                     input int settle, input bit spam);
    int         total;
    int         e;
    logic [3:0] m;
    logic [1:0] exp_drv;
    sel = s;
    if (s == 0) tt0 = tt;
    else        tt1 = tt;
    m = 4'd0;
    e = 0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] != exp_tt[v]) begin
        m[v] = 1'b1;
        e++;
      end
    end
    total = 4 * (settle + 1);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    check_eq("accept", obs, 12'h800);
    set_start(s, spam ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int k = 1; k <= total; k++) begin
      @(posedge clk); #1;
      if (spam) set_start(s, 1'($urandom_range(0, 1)));
      check_eq("done", obs[10], k == total);
      check_eq("busy", obs[11], k != total);
      exp_drv = (k / (settle + 1) > 3) ? 2'd3 : 2'(k / (settle + 1));
      check_eq("drv", obs[1:0], exp_drv);
    end
    check_eq("pass", obs[9], e == 0);
    check_eq("err_count", obs[8:6], e);
    check_eq("fail_mask", obs[5:2], m);
    // Start possibly high during DONE must not be accepted on the DONE->IDLE edge.
    @(posedge clk); #1;
    set_start(s, 1'b0);
    check_eq("after_done", obs[11:10], 2'b00);
    check_eq("held", obs[9:0], {e == 0, 3'(e), m, 2'b11});
  endtask

  initial begin
    bit found;
    if0.start = 1'b0;
    if1.start = 1'b0;
    tt0       = 4'b1000;
    tt1       = 4'b0110;
    sel       = 0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("reset0", pack0, 0);
      check_eq("reset1", pack1, 0);
    end
    #2 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check_eq("idle0", pack0, 0);
      check_eq("idle1", pack1, 0);
    end

    // Directed: AND, OR, stuck-at-1, then AND again to show results clear.
    run(0, 4'b1000, 4'b1000, 1, 1'b0);
    run(0, 4'b1110, 4'b1000, 1, 1'b0);
    run(0, 4'b1111, 4'b1000, 1, 1'b0);
    run(0, 4'b1000, 4'b1000, 1, 1'b0);

    // SETTLE=3 instance with random start activity while busy.
    run(1, 4'b0110, 4'b0110, 3, 1'b1);
    run(1, 4'($urandom_range(0, 15)), 4'b0110, 3, 1'b1);

    // Random gate functions with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run(0, 4'($urandom_range(0, 15)), 4'b1000, 1, 1'b0);
    end

    // Reset while vector 10 is applied.
    sel       = 0;
    tt0       = 4'b1110;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (pack0[1:0] == 2'b10) found = 1'b1;
    end
    check_eq("mid_reach_idx2", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_async_clear", pack0, 0);
    @(posedge clk); #1;
    check_eq("mid_reset_hold", pack0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_idle", pack0, 0);
    run(0, 4'b1000, 4'b1000, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
